// File: rtl/reorder_buffer_if.sv
// Reorder-buffer bus bundle: decoder allocate/query, CDB writeback and retire outputs.
// The slave side is the ROB itself; the master side is its surrounding pipeline.
interface reorder_buffer_if #(
    parameter int unsigned ROB_ADDR = 4
);
    logic                issue_valid;
    logic [1:0]          issue_type;
    logic [4:0]          issue_rd;
    logic                issue_ready;
    logic [31:0]         issue_val;
    logic                issue_pred_taken;
    logic [31:0]         issue_alt_pc;
    logic                rob_full;
    logic [ROB_ADDR-1:0] alloc_id;

    logic                cdb_alu_valid;
    logic [ROB_ADDR-1:0] cdb_alu_id;
    logic [31:0]         cdb_alu_val;
    logic                cdb_alu_taken;
    logic                cdb_lsb_valid;
    logic [ROB_ADDR-1:0] cdb_lsb_id;
    logic [31:0]         cdb_lsb_val;

    logic [ROB_ADDR-1:0] q1_id;
    logic [ROB_ADDR-1:0] q2_id;
    logic                q1_ready;
    logic                q2_ready;
    logic [31:0]         q1_val;
    logic [31:0]         q2_val;

    logic                commit_config;
    logic [4:0]          rs_to_write_id;
    logic [31:0]         rs_to_write_val;
    logic [ROB_ADDR-1:0] commit_rob_id;
    logic                store_commit;
    logic [ROB_ADDR-1:0] store_commit_id;
    logic                rollback_config;
    logic [31:0]         rollback_pc;

    modport master (
        output issue_valid, issue_type, issue_rd, issue_ready, issue_val, issue_pred_taken,
        output issue_alt_pc,
        output cdb_alu_valid, cdb_alu_id, cdb_alu_val, cdb_alu_taken,
        output cdb_lsb_valid, cdb_lsb_id, cdb_lsb_val,
        output q1_id, q2_id,
        input  rob_full, alloc_id, q1_ready, q2_ready, q1_val, q2_val,
        input  commit_config, rs_to_write_id, rs_to_write_val, commit_rob_id,
        input  store_commit, store_commit_id, rollback_config, rollback_pc
    );

    modport slave (
        input  issue_valid, issue_type, issue_rd, issue_ready, issue_val, issue_pred_taken,
        input  issue_alt_pc,
        input  cdb_alu_valid, cdb_alu_id, cdb_alu_val, cdb_alu_taken,
        input  cdb_lsb_valid, cdb_lsb_id, cdb_lsb_val,
        input  q1_id, q2_id,
        output rob_full, alloc_id, q1_ready, q2_ready, q1_val, q2_val,
        output commit_config, rs_to_write_id, rs_to_write_val, commit_rob_id,
        output store_commit, store_commit_id, rollback_config, rollback_pc
    );
endinterface

// File: rtl/reorder_buffer.sv
// Reorder buffer: circular queue allocating in program order, capturing CDB results and
// retiring one entry per cycle into register commit, store release or misprediction rollback.
module reorder_buffer #(
    parameter int unsigned ROB_ADDR = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    reorder_buffer_if.slave bus
);
    localparam int unsigned         Depth      = 2 ** ROB_ADDR;
    localparam logic [ROB_ADDR:0]   FullCount  = (ROB_ADDR + 1)'(Depth);
    localparam logic [ROB_ADDR-1:0] PtrOne     = ROB_ADDR'(1);
    localparam logic [1:0]          TypeReg    = 2'd0;
    localparam logic [1:0]          TypeStore  = 2'd1;
    localparam logic [1:0]          TypeBranch = 2'd2;

    logic [Depth-1:0]    r_busy;
    logic [Depth-1:0]    r_ready;
    logic [Depth-1:0]    r_pred;
    logic [Depth-1:0]    r_act;
    logic [1:0]          r_type [Depth];
    logic [4:0]          r_rd   [Depth];
    logic [31:0]         r_val  [Depth];
    logic [31:0]         r_alt  [Depth];
    logic [ROB_ADDR-1:0] r_head;
    logic [ROB_ADDR-1:0] r_tail;
    logic [ROB_ADDR:0]   r_count;

    logic                r_commit;
    logic [4:0]          r_rs_id;
    logic [31:0]         r_rs_val;
    logic [ROB_ADDR-1:0] r_commit_id;
    logic                r_store;
    logic [ROB_ADDR-1:0] r_store_id;
    logic                r_rollback;
    logic [31:0]         r_rollback_pc;

    logic w_full;
    logic w_retire;
    logic w_mispredict;
    logic w_alloc;
    logic w_alu_hit;
    logic w_lsb_hit;

    always_comb begin
        w_full       = (r_count == FullCount);
        w_retire     = r_busy[r_head] && r_ready[r_head];
        w_mispredict = w_retire && (r_type[r_head] == TypeBranch) &&
                       (r_act[r_head] != r_pred[r_head]);
        w_alloc      = bus.issue_valid && !w_full && !r_rollback;
        w_alu_hit    = bus.cdb_alu_valid && r_busy[bus.cdb_alu_id] && !r_rollback;
        // ALU has priority when both buses target the same entry
        w_lsb_hit    = bus.cdb_lsb_valid && r_busy[bus.cdb_lsb_id] && !r_rollback &&
                       !(bus.cdb_alu_valid && (bus.cdb_alu_id == bus.cdb_lsb_id));
    end

    function automatic logic [32:0] lookup(input logic [ROB_ADDR-1:0] id);
        logic [32:0] res;
        res = '0;
        if (r_busy[id]) begin
            if (bus.cdb_alu_valid && (bus.cdb_alu_id == id)) begin
                res = {1'b1, bus.cdb_alu_val};
            end else if (bus.cdb_lsb_valid && (bus.cdb_lsb_id == id)) begin
                res = {1'b1, bus.cdb_lsb_val};
            end else if (r_ready[id]) begin
                res = {1'b1, r_val[id]};
            end
        end
        return res;
    endfunction

    assign {bus.q1_ready, bus.q1_val} = lookup(bus.q1_id);
    assign {bus.q2_ready, bus.q2_val} = lookup(bus.q2_id);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy        <= '0;
            r_ready       <= '0;
            r_pred        <= '0;
            r_act         <= '0;
            for (int i = 0; i < Depth; i++) begin
                r_type[i] <= '0;
                r_rd[i]   <= '0;
                r_val[i]  <= '0;
                r_alt[i]  <= '0;
            end
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_commit      <= 1'b0;
            r_rs_id       <= '0;
            r_rs_val      <= '0;
            r_commit_id   <= '0;
            r_store       <= 1'b0;
            r_store_id    <= '0;
            r_rollback    <= 1'b0;
            r_rollback_pc <= '0;
        end else if (rdy) begin
            r_commit   <= 1'b0;
            r_store    <= 1'b0;
            r_rollback <= 1'b0;
            if (w_mispredict) begin
                // Flush discards any same-cycle allocate and writeback
                r_rollback    <= 1'b1;
                r_rollback_pc <= r_alt[r_head];
                r_busy        <= '0;
                r_head        <= '0;
                r_tail        <= '0;
                r_count       <= '0;
            end else begin
                if (w_alu_hit) begin
                    r_ready[bus.cdb_alu_id] <= 1'b1;
                    r_val[bus.cdb_alu_id]   <= bus.cdb_alu_val;
                    r_act[bus.cdb_alu_id]   <= bus.cdb_alu_taken;
                end
                if (w_lsb_hit) begin
                    r_ready[bus.cdb_lsb_id] <= 1'b1;
                    r_val[bus.cdb_lsb_id]   <= bus.cdb_lsb_val;
                end
                if (w_retire) begin
                    r_busy[r_head] <= 1'b0;
                    r_head         <= r_head + PtrOne;
                    if (r_type[r_head] == TypeReg) begin
                        r_commit    <= 1'b1;
                        r_rs_id     <= r_rd[r_head];
                        r_rs_val    <= r_val[r_head];
                        r_commit_id <= r_head;
                    end else if (r_type[r_head] == TypeStore) begin
                        r_store    <= 1'b1;
                        r_store_id <= r_head;
                    end
                end
                if (w_alloc) begin
                    r_busy[r_tail]  <= 1'b1;
                    r_ready[r_tail] <= bus.issue_ready;
                    r_type[r_tail]  <= bus.issue_type;
                    r_rd[r_tail]    <= bus.issue_rd;
                    r_val[r_tail]   <= bus.issue_ready ? bus.issue_val : 32'd0;
                    r_pred[r_tail]  <= bus.issue_pred_taken;
                    r_act[r_tail]   <= bus.issue_pred_taken;
                    r_alt[r_tail]   <= bus.issue_alt_pc;
                    r_tail          <= r_tail + PtrOne;
                end
                r_count <= r_count + (ROB_ADDR + 1)'(w_alloc) - (ROB_ADDR + 1)'(w_retire);
            end
        end else begin
            r_commit   <= 1'b0;
            r_store    <= 1'b0;
            r_rollback <= 1'b0;
        end
    end

    assign bus.rob_full        = w_full;
    assign bus.alloc_id        = r_tail;
    assign bus.commit_config   = r_commit;
    assign bus.rs_to_write_id  = r_rs_id;
    assign bus.rs_to_write_val = r_rs_val;
    assign bus.commit_rob_id   = r_commit_id;
    assign bus.store_commit    = r_store;
    assign bus.store_commit_id = r_store_id;
    assign bus.rollback_config = r_rollback;
    assign bus.rollback_pc     = r_rollback_pc;
endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized scoreboard bench for reorder_buffer: a program-order queue model predicts
// retire events per edge; a negedge monitor pops and compares them against DUT pulses.
module tb_reorder_buffer;
    typedef struct {
        logic [3:0]  rid;
        logic [1:0]  typ;
        logic [4:0]  rd;
        bit          done;
        logic [31:0] val;
        bit          pred;
        bit          act;
        logic [31:0] alt;
    } ent_t;

    // kind: bit0 register commit, bit1 store release, bit2 rollback (val carries the pc)
    typedef struct {
        logic [2:0]  kind;
        int          cyc;
        logic [3:0]  id;
        logic [4:0]  rd;
        logic [31:0] val;
    } ev_t;

    logic clk;
    logic rst;
    logic rdy;

    reorder_buffer_if #(.ROB_ADDR(4)) bus ();

    reorder_buffer #(.ROB_ADDR(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    ent_t       mq[$];
    ev_t        exp_q[$];
    logic [3:0] mtail;
    bit         m_rb;
    int         edge_n;
    bit         mon_en;
    int         n_chk;
    int         n_pass;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, want, edge_n);
    endtask

    function automatic logic [32:0] model_q(input logic [3:0] id);
        logic [32:0] res;
        res = 33'd0;
        for (int k = 0; k < mq.size(); k++) begin
            if (mq[k].rid == id) begin
                if (bus.cdb_alu_valid && bus.cdb_alu_id == id) res = {1'b1, bus.cdb_alu_val};
                else if (bus.cdb_lsb_valid && bus.cdb_lsb_id == id) res = {1'b1, bus.cdb_lsb_val};
                else if (mq[k].done) res = {1'b1, mq[k].val};
            end
        end
        return res;
    endfunction

    // Reference model: advances once per rising edge from the inputs held across it
    always @(posedge clk) begin
        ev_t  ev;
        ent_t e;
        bit   full0;
        bit   retire;
        bit   misp;
        edge_n++;
        retire = 1'b0;
        misp   = 1'b0;
        if (rst) begin
            mq.delete();
            mtail = 4'd0;
            m_rb  = 1'b0;
        end else if (!rdy) begin
            m_rb = 1'b0;
        end else begin
            full0 = (mq.size() == 16);
            if (mq.size() != 0 && mq[0].done) begin
                retire  = 1'b1;
                e       = mq[0];
                ev.cyc  = edge_n;
                ev.id   = e.rid;
                ev.rd   = e.rd;
                ev.val  = e.val;
                ev.kind = 3'b000;
                if (e.typ == 2'd0) ev.kind = 3'b001;
                else if (e.typ == 2'd1) ev.kind = 3'b010;
                else if (e.act != e.pred) begin
                    ev.kind = 3'b100;
                    ev.val  = e.alt;
                    misp    = 1'b1;
                end
                if (ev.kind != 3'b000 && mon_en) exp_q.push_back(ev);
            end
            if (misp) begin
                mq.delete();
                mtail = 4'd0;
            end else begin
                if (!m_rb) begin
                    for (int k = 0; k < mq.size(); k++) begin
                        if (bus.cdb_alu_valid && mq[k].rid == bus.cdb_alu_id) begin
                            mq[k].done = 1'b1;
                            mq[k].val  = bus.cdb_alu_val;
                            mq[k].act  = bus.cdb_alu_taken;
                        end else if (bus.cdb_lsb_valid && mq[k].rid == bus.cdb_lsb_id) begin
                            mq[k].done = 1'b1;
                            mq[k].val  = bus.cdb_lsb_val;
                        end
                    end
                end
                if (retire) void'(mq.pop_front());
                if (bus.issue_valid && !full0 && !m_rb) begin
                    e.rid  = mtail;
                    e.typ  = bus.issue_type;
                    e.rd   = bus.issue_rd;
                    e.done = bus.issue_ready;
                    e.val  = bus.issue_ready ? bus.issue_val : 32'd0;
                    e.pred = bus.issue_pred_taken;
                    e.act  = bus.issue_pred_taken;
                    e.alt  = bus.issue_alt_pc;
                    mq.push_back(e);
                    mtail = mtail + 4'd1;
                end
            end
            m_rb = misp;
        end
    end

    // Monitor: one sample per cycle, between edges
    always @(negedge clk) begin
        ev_t        ev;
        logic [2:0] obs;
        logic [2:0] want;
        bit         have;
        if (mon_en) begin
            obs  = {bus.rollback_config, bus.store_commit, bus.commit_config};
            have = (exp_q.size() != 0) && (exp_q[0].cyc == edge_n);
            want = have ? exp_q[0].kind : 3'b000;
            chk("pulses", 64'(obs), 64'(want));
            if (have) begin
                ev = exp_q.pop_front();
                if (ev.kind == 3'b001) begin
                    chk("rs_to_write_id", 64'(bus.rs_to_write_id), 64'(ev.rd));
                    chk("rs_to_write_val", 64'(bus.rs_to_write_val), 64'(ev.val));
                    chk("commit_rob_id", 64'(bus.commit_rob_id), 64'(ev.id));
                end else if (ev.kind == 3'b010) begin
                    chk("store_commit_id", 64'(bus.store_commit_id), 64'(ev.id));
                end else begin
                    chk("rollback_pc", 64'(bus.rollback_pc), 64'(ev.val));
                end
            end
            chk("rob_full", 64'(bus.rob_full), 64'(mq.size() == 16));
            chk("alloc_id", 64'(bus.alloc_id), 64'(mtail));
            chk("q1", 64'({bus.q1_ready, bus.q1_val}), 64'(model_q(bus.q1_id)));
            chk("q2", 64'({bus.q2_ready, bus.q2_val}), 64'(model_q(bus.q2_id)));
        end
    end

    task automatic drive(input int unsigned p_rdy, input int unsigned p_issue,
                         input int unsigned p_wb, input int unsigned p_misp);
        int unsigned k;
        rdy                  = ($urandom_range(99) < p_rdy);
        bus.issue_valid      = ($urandom_range(99) < p_issue);
        k                    = $urandom_range(9);
        bus.issue_type       = (k < 5) ? 2'd0 : ((k < 7) ? 2'd1 : 2'd2);
        bus.issue_rd         = 5'($urandom);
        bus.issue_ready      = ($urandom_range(3) == 0);
        bus.issue_val        = $urandom;
        bus.issue_pred_taken = 1'($urandom);
        bus.issue_alt_pc     = $urandom;
        bus.cdb_alu_valid    = 1'b0;
        bus.cdb_alu_id       = 4'($urandom);
        bus.cdb_alu_val      = $urandom;
        bus.cdb_alu_taken    = 1'($urandom);
        bus.cdb_lsb_valid    = 1'b0;
        bus.cdb_lsb_id       = 4'($urandom);
        bus.cdb_lsb_val      = $urandom;
        if (mq.size() != 0 && $urandom_range(99) < p_wb) begin
            k                 = $urandom_range(32'(mq.size() - 1));
            bus.cdb_alu_valid = 1'b1;
            bus.cdb_alu_id    = mq[k].rid;
            bus.cdb_alu_taken = ($urandom_range(99) < p_misp) ? ~mq[k].pred : mq[k].pred;
        end else if ($urandom_range(15) == 0) begin
            bus.cdb_alu_valid = 1'b1;
        end
        if (mq.size() != 0 && $urandom_range(99) < p_wb) begin
            k                 = $urandom_range(32'(mq.size() - 1));
            bus.cdb_lsb_valid = 1'b1;
            bus.cdb_lsb_id    = mq[k].rid;
        end else if ($urandom_range(15) == 0) begin
            bus.cdb_lsb_valid = 1'b1;
        end
        bus.q1_id = 4'($urandom);
        bus.q2_id = (mq.size() != 0) ? mq[$urandom_range(32'(mq.size() - 1))].rid
                                     : 4'($urandom);
    endtask

    task automatic tick(input int unsigned p_rdy, input int unsigned p_issue,
                        input int unsigned p_wb, input int unsigned p_misp);
        @(posedge clk);
        #1;
        drive(p_rdy, p_issue, p_wb, p_misp);
    endtask

    initial begin
        int guard;
        n_chk  = 0;
        n_pass = 0;
        edge_n = 0;
        mon_en = 1'b0;
        rst    = 1'b1;
        drive(100, 0, 0, 0);
        bus.issue_valid   = 1'b1;
        bus.cdb_alu_valid = 1'b0;
        bus.cdb_lsb_valid = 1'b0;
        bus.q1_id         = 4'd0;
        bus.q2_id         = 4'd0;
        rdy               = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        // Reset dominates rdy and a pending issue
        chk("reset rob_full", 64'(bus.rob_full), 64'd0);
        chk("reset alloc_id", 64'(bus.alloc_id), 64'd0);
        chk("reset commit_config", 64'(bus.commit_config), 64'd0);
        chk("reset store_commit", 64'(bus.store_commit), 64'd0);
        chk("reset rollback_config", 64'(bus.rollback_config), 64'd0);
        chk("reset rs_to_write_id", 64'(bus.rs_to_write_id), 64'd0);
        chk("reset rs_to_write_val", 64'(bus.rs_to_write_val), 64'd0);
        chk("reset commit_rob_id", 64'(bus.commit_rob_id), 64'd0);
        chk("reset store_commit_id", 64'(bus.store_commit_id), 64'd0);
        chk("reset rollback_pc", 64'(bus.rollback_pc), 64'd0);
        chk("reset q1", 64'({bus.q1_ready, bus.q1_val}), 64'd0);
        rst    = 1'b0;
        mon_en = 1'b1;
        drive(100, 0, 0, 0);
        repeat (10) tick(100, 0, 0, 0);
        repeat (24) tick(100, 100, 0, 0);
        repeat (40) tick(100, 100, 40, 0);
        repeat (500) tick(70, 60, 50, 8);
        repeat (1000) tick(90, 70, 35, 5);
        guard = 0;
        while (mq.size() != 0 && guard < 400) begin
            tick(100, 0, 100, 0);
            guard++;
        end
        if (mq.size() != 0) chk("drain bound", 64'(mq.size()), 64'd0);
        repeat (4) tick(100, 0, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
